// File: rtl/arb16_burst_ctrl_pkg.sv
// Shared types and constants for the 16-way burst-locking arbiter.
package arb_pkg;
    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [ID_W-1:0]  req_id_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/arb16_burst_ctrl_rr_pick16.sv
// Combinational round-robin picker: first set bit of vec at or above ptr, wrapping 15->0.
module rr_pick16
    import arb_pkg::*;
(
    input  req_vec_t vec,
    input  req_id_t  ptr,
    output req_vec_t oh,
    output req_id_t  id,
    output logic     any
);
    req_id_t idx;

    always_comb begin
        oh  = '0;
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!any && vec[idx]) begin
                any     = 1'b1;
                id      = idx;
                oh[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arb16_burst_ctrl.sv
// Burst-locking round-robin controller for 16 requesters, registered outputs.
// Optional beat limit per grant enabled by defining ARB_BURST_LIMIT_EN.
module arb16_burst_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t req,
    input  req_vec_t last,
    input  logic     beat_ack,
    output req_vec_t grant,
    output logic     grant_vld,
    output req_id_t  grant_id,
    output logic     abort
);
    arb_state_e state_q, state_d;
    req_id_t    ptr_q, ptr_d;
    req_vec_t   grant_q, grant_d;
    req_id_t    grant_id_q, grant_id_d;
    logic       grant_vld_q, grant_vld_d;
    logic       abort_q, abort_d;

    logic       own, rel_a, rel_b, rel_c, rel, is_abort;
    req_vec_t   pick_vec, pick_oh;
    req_id_t    pick_ptr, pick_id;
    logic       pick_any;

`ifdef ARB_BURST_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    assign rel_c = own & beat_ack & (cnt_q == 8'(MAX_BEATS - 1));
`else
    logic unused_max_beats;
    assign unused_max_beats = ^MAX_BEATS;
    assign rel_c = 1'b0;
`endif

    assign own      = (state_q == OWN);
    assign rel_a    = own & beat_ack & last[grant_id_q];
    assign rel_b    = own & ~req[grant_id_q];
    assign rel      = rel_a | rel_b | rel_c;
    assign is_abort = rel_b & ~rel_a;

    // One picker serves both the IDLE search and the handoff search.
    always_comb begin
        pick_ptr = ptr_q;
        pick_vec = req;
        if (rel) begin
            pick_ptr = grant_id_q + 1'b1;
            if (is_abort) pick_vec[grant_id_q] = 1'b0;
        end
    end

    rr_pick16 u_pick (
        .vec (pick_vec),
        .ptr (pick_ptr),
        .oh  (pick_oh),
        .id  (pick_id),
        .any (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        abort_d    = is_abort;
`ifdef ARB_BURST_LIMIT_EN
        cnt_d      = cnt_q;
`endif
        if (!own || rel) begin
            if (rel) ptr_d = pick_ptr;
            if (pick_any) begin
                state_d    = OWN;
                grant_d    = pick_oh;
                grant_id_d = pick_id;
`ifdef ARB_BURST_LIMIT_EN
                cnt_d      = '0;
`endif
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (beat_ack && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
`endif
        grant_vld_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
            abort_q     <= abort_d;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign grant     = grant_q;
    assign grant_vld = grant_vld_q;
    assign grant_id  = grant_id_q;
    assign abort     = abort_q;
endmodule

// File: tb/tb_arb16_burst_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_arb16_burst_ctrl;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req, last;
    logic        beat_ack;
    logic [15:0] grant;
    logic        grant_vld;
    logic [3:0]  grant_id;
    logic        abort;

    int errs = 0;
    int checks = 0;

    // model state
    int m_own, m_ptr, m_id, m_cnt;
    bit m_abort;

    always #5 clk = ~clk;

    arb16_burst_ctrl #(.MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .beat_ack  (beat_ack),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .abort     (abort)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] v, input int p);
        for (int i = 0; i < 16; i++)
            if (v[(p + i) % 16]) return (p + i) % 16;
        return -1;
    endfunction

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_id = 0; m_cnt = 0; m_abort = 0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic [15:0] l, input logic a);
        bit ra, rb, rc;
        int w;
        logic [15:0] v;
        m_abort = 0;
        if (m_own < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin m_own = w; m_id = w; m_cnt = 0; end
        end else begin
            ra = a && l[m_own];
            rb = !r[m_own];
            rc = 0;
`ifdef ARB_BURST_LIMIT_EN
            rc = a && (m_cnt == MAXB - 1);
`endif
            if (ra || rb || rc) begin
                m_ptr = (m_own + 1) % 16;
                v = r;
                if (rb && !ra) begin v[m_own] = 1'b0; m_abort = 1; end
                w = pick(v, m_ptr);
                if (w >= 0) begin m_own = w; m_id = w; m_cnt = 0; end
                else m_own = -1;
            end else if (a && m_cnt < 255) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        logic [31:0] eg;
        eg = (m_own >= 0) ? (32'h1 << m_own) : 32'h0;
        chk({tag, ".grant"}, {16'h0, grant}, eg);
        chk({tag, ".vld"}, {31'h0, grant_vld}, {31'h0, m_own >= 0});
        chk({tag, ".id"}, {28'h0, grant_id}, m_id);
        chk({tag, ".abort"}, {31'h0, abort}, {31'h0, m_abort});
    endtask

    // drive one cycle, advance model, check registered outputs just after the edge
    task automatic cyc(input logic [15:0] r, input logic [15:0] l, input logic a, input string tag);
        req = r; last = l; beat_ack = a;
        model_step(r, l, a);
        @(posedge clk); #1;
        check_outs(tag);
    endtask

    initial begin
        logic [15:0] r, l, flip;
        int prev;
        rst_n = 1'b0; req = '0; last = '0; beat_ack = 1'b0;
        model_reset();
        #2;
        check_outs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // two requesters, normal burst end hands off with no gap
        cyc(16'h0021, 16'h0000, 1'b0, "t1_grant");
        chk("t1_g0", {16'h0, grant}, 32'h0001);
        cyc(16'h0021, 16'h0001, 1'b1, "t1_hand");
        chk("t1_g5", {16'h0, grant}, 32'h0020);

        // owner 5 drops mid-burst with 9 pending
        cyc(16'h0220, 16'h0000, 1'b1, "t3_beat");
        cyc(16'h0200, 16'h0000, 1'b0, "t3_drop");
        chk("t3_abort", {31'h0, abort}, 32'h1);
        chk("t3_g9", {16'h0, grant}, 32'h0200);
        cyc(16'h0200, 16'h0000, 1'b0, "t3_after");
        chk("t3_abort_off", {31'h0, abort}, 32'h0);

        // all requesting, one-beat bursts: strict rotation
        for (int i = 0; i < 17; i++) begin
            prev = grant_id;
            cyc(16'hFFFF, 16'hFFFF, 1'b1, "t2_rot");
            chk("t2_next", {28'h0, grant_id}, (prev + 1) % 16);
        end

`ifdef ARB_BURST_LIMIT_EN
        // owner 3 never ends, 7 pending: forced release after MAXB beats
        cyc(16'h0000, 16'h0000, 1'b0, "t4_idle");
        cyc(16'h0008, 16'h0000, 1'b0, "t4_g3");
        for (int i = 0; i < MAXB; i++) cyc(16'h0088, 16'h0000, 1'b1, "t4_beat");
        chk("t4_id7", {28'h0, grant_id}, 32'd7);
        chk("t4_noabort", {31'h0, abort}, 32'h0);
        // lone requester 2 is re-granted right after the limit
        cyc(16'h0000, 16'h0000, 1'b0, "t5_idle");
        cyc(16'h0004, 16'h0000, 1'b0, "t5_g2");
        for (int i = 0; i < 2 * MAXB + 1; i++) begin
            cyc(16'h0004, 16'h0000, 1'b1, "t5_beat");
            chk("t5_still2", {16'h0, grant}, 32'h0004);
        end
`endif

        // reset in the middle of a long burst
        cyc(16'h0000, 16'h0000, 1'b0, "t6_idle");
        cyc(16'h0400, 16'h0000, 1'b0, "t6_g10");
        for (int i = 0; i < 3; i++) cyc(16'hFFFF, 16'h0000, 1'b1, "t6_beat");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_grant", {16'h0, grant}, 32'h0);
        chk("t6_async_vld", {31'h0, grant_vld}, 32'h0);
        chk("t6_async_abort", {31'h0, abort}, 32'h0);
        @(posedge clk); #1;
        check_outs("t6_inrst");
        rst_n = 1'b1;
        cyc(16'hFFFF, 16'h0000, 1'b0, "t6_first");
        chk("t6_ptr0", {28'h0, grant_id}, 32'd0);

        // random traffic
        r = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            flip = '0;
            for (int b = 0; b < 16; b++) begin
                if (b == m_own) flip[b] = ($urandom_range(0, 31) == 0);
                else            flip[b] = ($urandom_range(0, 7) == 0);
            end
            r = r ^ flip;
            l = 16'($urandom) & 16'($urandom);
            cyc(r, l, 1'($urandom_range(0, 1)), "rnd");
            checks++;
            if (!$onehot0(grant)) begin
                errs++;
                $display("FAIL rnd.onehot got=%0h exp=onehot0", grant);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/arb16_burst_ctrl.md
# arb16_burst_ctrl

Burst-locking round-robin controller for 16 requesters sharing one downstream beat channel. It sits in front of the shared resource in the 16-way arbitration tree. It picks one requester, holds the grant across a multi-beat burst until the owner's final beat is accepted, then passes ownership on in round-robin order with no idle bubble. All outputs are registered.

## Interface
- `N_REQ`, 16: number of requesters. Fixed at 16; taken from the package constant.
- `MAX_BEATS`, 16: beat limit per grant. Used only when `ARB_BURST_LIMIT_EN` is defined; legal range 1..255.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset; deassertion is synchronous to `clk` at system level.
- `req`  in  16: per-requester request level; held high for the whole burst.
- `last`  in  16: per-requester final-beat marker; sampled only for the current owner.
- `beat_ack`  in  1: downstream accepted one beat from the owner this cycle.
- `grant`  out  16: one-hot owner, or all zero.
- `grant_vld`  out  1: equals `|grant`.
- `grant_id`  out  4: binary index of the owner; holds its last value when `grant_vld`=0.
- `abort`  out  1: one-cycle pulse when a grant ends without `last`.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - OWN: `grant` is held.
- Round-robin pointer `ptr` (4 bits):
  - Selection searches `req` starting at index `ptr`, ascending, wrapping 15→0. The first set bit wins.
- IDLE → OWN when `|req`=1. The winner is registered into `grant`/`grant_id`.
- In OWN, a release event occurs in any cycle where one of these holds:
  - (a) `beat_ack` & `last[grant_id]`: normal end of burst.
  - (b) `req[grant_id]`=0: requester dropped; this is an abort.
  - (c) with `ARB_BURST_LIMIT_EN` defined: `beat_ack` & beat counter = `MAX_BEATS`-1, which forces release.
- On a release:
  - `ptr` ← `grant_id`+1 mod 16.
  - Re-select over the current-cycle `req` using that new pointer, with the releasing owner's bit masked only for case (b).
  - If a winner exists, stay in OWN with the new owner. Otherwise go to IDLE and clear `grant`.
- Simultaneous (a) and (b): treat as a normal end. `abort` stays 0.
- `abort` pulses for (b) only. A forced release under (c) is not an abort.
- `last` or `beat_ack` with no owner is ignored.
- Beat counter:
  - Width 8 bits.
  - Clears on every new grant.
  - Increments on `beat_ack` while in OWN.
  - Saturates; never wraps.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant`=0, `grant_vld`=0, `grant_id`=0, `abort`=0, counter=0.
- Grant latency: `req` seen high at edge k from IDLE → `grant` valid after edge k.
- Handoff has zero bubble: release at edge k → the next owner's `grant` is visible after edge k. `grant` is never two-hot or X.
- Reset asserted mid-burst: all outputs clear immediately and asynchronously. No release side effects (no `abort`, no pointer update).
- `abort` is high for exactly one cycle, in the cycle after edge k.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - Beat counter compared against `MAX_BEATS`.
  - Forced release after the `MAX_BEATS`-th accepted beat, even if `req` stays high. The same requester may be re-granted only if no other requester is pending.
- Not defined:
  - Counter and compare logic compiled out.
  - A grant lasts until `last` or request drop; `MAX_BEATS` is ignored.

## Structure
- Package `arb_pkg`:
  - `N_REQ`=16, `ID_W`=4.
  - typedef `req_vec_t` (logic [15:0]).
  - typedef `req_id_t` (logic [3:0]).
  - enum `arb_state_e` {IDLE, OWN}.
- Sub-module `rr_pick16`:
  - Purely combinational.
  - Inputs: `req_vec_t` vector, `ptr`.
  - Outputs: one-hot winner, binary id, `any`.
  - Instantiated once. Release and IDLE selection share it by muxing the pointer and mask into it.

## Test plan
- Reset then `req`=16'h0021 → after one edge `grant`=16'h0001, `grant_id`=0. On `beat_ack`&`last[0]` → `grant`=16'h0020 the next cycle with no gap; `ptr`=1.
- All 16 requesters high, each burst 1 beat with `last`=1 → grants cycle 0,1,…,15,0 in order, one per cycle.
- Owner 5 drops `req` mid-burst while `req[9]`=1 → `abort`=1 for one cycle; `grant`=16'h0200 the next cycle.
- `ARB_BURST_LIMIT_EN`, `MAX_BEATS`=4, owner 3 never asserts `last`, `req[7]` pending → release after the 4th `beat_ack`; `grant_id`=7 and `abort`=0.
- Only requester 2 active, same burst-limit setup → re-granted to 2 in the cycle after the forced release with no gap; counter restarts at 0.
- `rst_n` pulsed low during a 10-beat burst → `grant`=0 asynchronously. After release the first grant search starts at `ptr`=0.
